// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns one RISC-V load/store into one or two
// word-aligned memory accesses and returns extended load data.
module lsu_mem_master #(
   parameter int Width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [2:0]       req_funct3,
   input  logic [Width-1:0] req_addr,
   input  logic [Width-1:0] req_wdata,
   output logic             resp_valid,
   output logic [Width-1:0] resp_rdata,
   output logic             resp_err,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [Width-1:0] mem_addr,
   output logic [Width-1:0] mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ready,
   input  logic [Width-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic             r_write;
   logic [2:0]       r_f3;
   logic [Width-1:0] r_addr;
   logic [Width-1:0] r_wdata;
   logic [Width-1:0] r_rd0;
   logic [Width-1:0] r_rdata;
   logic             r_err;

   logic               w_f3_ok;
   logic [3:0]         w_mask;
   logic [7:0]         w_be8;
   logic               w_split;
   logic [2*Width-1:0] w_wd64;
   logic [2*Width-1:0] w_sh64;
   logic [Width-1:0]   w_lo;
   logic [Width-1:0]   w_hi;
   logic [Width-1:0]   w_ext;
   logic [Width-1:0]   w_ld;
   logic [Width-1:0]   w_addr0;
   logic [Width-1:0]   w_addr1;
   logic               w_done;
   logic [4:0]         w_shamt;

   always_comb begin
      w_f3_ok = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = !req_write;
         default:                w_f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_mask = 4'b1111;
      case (r_f3[1:0])
         2'b00:   w_mask = 4'b0001;
         2'b01:   w_mask = 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   // Upper nibble of the shifted mask is the second-word portion.
   assign w_be8   = {4'b0000, w_mask} << r_addr[1:0];
   assign w_split = |w_be8[7:4];
   assign w_shamt = {r_addr[1:0], 3'b000};
   assign w_wd64  = {{Width{1'b0}}, r_wdata} << w_shamt;
   assign w_addr0 = {r_addr[Width-1:2], 2'b00};
   assign w_addr1 = {r_addr[Width-1:2] + 30'd1, 2'b00};

   assign w_lo   = (r_state == ACC1) ? r_rd0 : mem_rdata;
   assign w_hi   = (r_state == ACC1) ? mem_rdata : '0;
   assign w_sh64 = {w_hi, w_lo} >> w_shamt;

   always_comb begin
      w_ext = w_sh64[Width-1:0];
      case (r_f3)
         3'b000:  w_ext = {{24{w_sh64[7]}}, w_sh64[7:0]};
         3'b001:  w_ext = {{16{w_sh64[15]}}, w_sh64[15:0]};
         3'b100:  w_ext = {24'd0, w_sh64[7:0]};
         3'b101:  w_ext = {16'd0, w_sh64[15:0]};
         default: w_ext = w_sh64[Width-1:0];
      endcase
   end

   assign w_ld   = r_write ? '0 : w_ext;
   assign w_done = mem_ready &&
                   (((r_state == ACC0) && !w_split) ||
                    (r_state == ACC1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_state_nxt = w_f3_ok ? ACC0 : RESP;
            end
         end
         ACC0: begin
            if (mem_ready) begin
               w_state_nxt = w_split ? ACC1 : RESP;
            end
         end
         ACC1: begin
            if (mem_ready) begin
               w_state_nxt = RESP;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_write <= 1'b0;
         r_f3    <= 3'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd0   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_f3    <= req_funct3;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_err   <= !w_f3_ok;
               end
            end
            ACC0: begin
               if (mem_ready) begin
                  r_rd0 <= mem_rdata;
               end
            end
            RESP: begin
               r_rdata <= '0;
               r_err   <= 1'b0;
            end
            default: ;
         endcase
         if (w_done) begin
            r_rdata <= w_ld;
         end
      end
   end

   always_comb begin
      req_ready  = (r_state == IDLE);
      resp_valid = (r_state == RESP);
      resp_rdata = r_rdata;
      resp_err   = r_err;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = 4'b0000;
      case (r_state)
         ACC0: begin
            MemRead   = !r_write;
            MemWrite  = r_write;
            mem_addr  = w_addr0;
            mem_be    = w_be8[3:0];
            mem_wdata = w_wd64[Width-1:0];
         end
         ACC1: begin
            MemRead   = !r_write;
            MemWrite  = r_write;
            mem_addr  = w_addr1;
            mem_be    = w_be8[7:4];
            mem_wdata = w_wd64[2*Width-1:Width];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed loads/stores against a
// small word memory with optional wait states.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   lsu_mem_master #(.Width(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int stall_req = 0;
   int wait_cnt = 0;
   always @(posedge clk) begin
      if ((MemRead || MemWrite) && !mem_ready) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end
   assign mem_ready = (wait_cnt >= stall_req);

   always_comb begin
      case (mem_addr)
         32'h0000_0100: mem_rdata = 32'h4433_2211;
         32'h0000_0104: mem_rdata = 32'h8877_6655;
         32'hFFFF_FFFC: mem_rdata = 32'hDDCC_BBAA;
         32'h0000_0000: mem_rdata = 32'h1234_5678;
         default:       mem_rdata = 32'hDEAD_BEEF;
      endcase
   end

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } acc_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] cyc;
   } resp_t;

   acc_t  acc_q[$];
   resp_t resp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [79:0] got,
                      input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic exp_acc(input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
      acc_t e;
      e.wr = wr; e.addr = a; e.be = be; e.wd = wd;
      acc_q.push_back(e);
   endtask

   task automatic issue(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int stall, input logic [31:0] rd,
                        input logic err, input int lat);
      resp_t r;
      @(negedge clk);
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      chk("req_ready_idle", {79'd0, req_ready}, 80'd1);
      stall_req  = stall;
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      r.rdata = rd; r.err = err; r.cyc = cyc + lat;
      if (lat > 0) resp_q.push_back(r);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 40 && resp_q.size() != 0; i++) @(negedge clk);
      chk({nm, "_resp_done"}, 80'(resp_q.size()), 80'd0);
      chk({nm, "_acc_done"}, 80'(acc_q.size()), 80'd0);
      resp_q.delete();
      acc_q.delete();
      stall_req = 0;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (MemRead || MemWrite) begin
                  if (acc_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_access: addr %h be %b",
                              mem_addr, mem_be);
                  end else begin
                     chk("access",
                         {10'd0, MemRead, MemWrite, mem_addr, mem_be, mem_wdata},
                         {10'd0, !acc_q[0].wr, acc_q[0].wr, acc_q[0].addr,
                          acc_q[0].be, acc_q[0].wd});
                     if (mem_ready) acc_q.delete(0);
                  end
               end
               if (resp_valid) begin
                  if (resp_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_resp: rdata %h err %b",
                              resp_rdata, resp_err);
                  end else begin
                     chk("resp", {15'd0, resp_rdata, resp_err, cyc[31:0]},
                         {15'd0, resp_q[0].rdata, resp_q[0].err,
                          resp_q[0].cyc});
                     resp_q.delete(0);
                  end
               end
            end
         end
      join_none

      @(posedge clk);
      #1;
      chk("reset_vals",
          {{2'd0, req_ready, resp_valid, resp_err, MemRead, MemWrite,
            mem_be}, resp_rdata, mem_addr | mem_wdata},
          {{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}, 32'd0, 32'd0});
      @(negedge clk);
      rst = 1'b0;

      exp_acc(0, 32'h100, 4'b1111, 32'h0);
      issue(0, 3'b010, 32'h100, 32'h0, 0, 32'h4433_2211, 0, 2);
      drain("lw100");

      exp_acc(0, 32'h100, 4'b1000, 32'h0);
      issue(0, 3'b000, 32'h103, 32'h0, 0, 32'h0000_0044, 0, 2);
      drain("lb103");

      exp_acc(0, 32'h104, 4'b1000, 32'h0);
      issue(0, 3'b000, 32'h107, 32'h0, 0, 32'hFFFF_FF88, 0, 2);
      drain("lb107");

      exp_acc(0, 32'h104, 4'b1000, 32'h0);
      issue(0, 3'b100, 32'h107, 32'h0, 0, 32'h0000_0088, 0, 2);
      drain("lbu107");

      exp_acc(0, 32'h104, 4'b1100, 32'h0);
      issue(0, 3'b001, 32'h106, 32'h0, 0, 32'hFFFF_8877, 0, 2);
      drain("lh106");

      exp_acc(0, 32'h100, 4'b0110, 32'h0);
      issue(0, 3'b001, 32'h101, 32'h0, 0, 32'h0000_3322, 0, 2);
      drain("lh101");

      exp_acc(0, 32'h100, 4'b1100, 32'h0);
      exp_acc(0, 32'h104, 4'b0011, 32'h0);
      issue(0, 3'b010, 32'h102, 32'h0, 0, 32'h6655_4433, 0, 3);
      drain("lw102");

      exp_acc(0, 32'h100, 4'b1000, 32'h0);
      exp_acc(0, 32'h104, 4'b0001, 32'h0);
      issue(0, 3'b101, 32'h103, 32'h0, 0, 32'h0000_5544, 0, 3);
      drain("lhu103");

      exp_acc(1, 32'h100, 4'b1000, 32'hEF00_0000);
      exp_acc(1, 32'h104, 4'b0001, 32'h0000_00BE);
      issue(1, 3'b001, 32'h103, 32'h0000_BEEF, 0, 32'h0, 0, 3);
      drain("sh103");

      exp_acc(1, 32'h100, 4'b1111, 32'hCAFE_F00D);
      issue(1, 3'b010, 32'h100, 32'hCAFE_F00D, 0, 32'h0, 0, 2);
      drain("sw100");

      exp_acc(1, 32'h100, 4'b0010, 32'h0000_A500);
      issue(1, 3'b000, 32'h101, 32'h0000_00A5, 0, 32'h0, 0, 2);
      drain("sb101");

      exp_acc(0, 32'h100, 4'b1111, 32'h0);
      issue(0, 3'b010, 32'h100, 32'h0, 3, 32'h4433_2211, 0, 5);
      drain("lw_stall");

      issue(0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1, 1);
      drain("bad_ld");

      issue(1, 3'b100, 32'h104, 32'h1234, 0, 32'h0, 1, 1);
      drain("bad_st");

      exp_acc(0, 32'hFFFF_FFFC, 4'b1100, 32'h0);
      exp_acc(0, 32'h0000_0000, 4'b0011, 32'h0);
      issue(0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0, 32'h5678_DDCC, 0, 3);
      drain("lw_wrap");

      exp_acc(0, 32'h100, 4'b1100, 32'h0);
      issue(0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 0, 0);
      @(posedge clk);
      #1;
      chk("rst_in_acc1", {46'd0, MemRead, mem_addr, 1'b0},
          {46'd0, 1'b1, 32'h104, 1'b0});
      rst = 1'b1;
      #1;
      chk("rst_async", {42'd0, MemRead, MemWrite, mem_be, mem_addr},
          80'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", {79'd0, req_ready}, 80'd1);
      repeat (3) @(negedge clk);
      drain("rst_test");

      exp_acc(0, 32'h104, 4'b1111, 32'h0);
      issue(0, 3'b010, 32'h104, 32'h0, 0, 32'h8877_6655, 0, 2);
      drain("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the single-cycle core's execute stage and the word-organised data memory. Accepts one RISC-V load or store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW), converts it to word-aligned memory accesses with byte enables, and returns sign- or zero-extended load data. Misaligned halfword/word accesses that cross a word boundary are split into two sequential word accesses. Invalid funct3 encodings are rejected without touching memory.

## Interface
- Width, 32, data and address width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block accepts the request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 field for the load or store.
- req_addr  input  Width  byte address.
- req_wdata  input  Width  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  Width  extended load data; 0 for stores and errors.
- resp_err  output  1  invalid funct3; qualified by resp_valid.
- MemRead  output  1  word read strobe.
- MemWrite  output  1  word write strobe.
- mem_addr  output  Width  word-aligned byte address; bits [1:0] = 0.
- mem_wdata  output  Width  lane-positioned write data.
- mem_be  output  4  byte enables; bit i enables bits [8i+7:8i].
- mem_ready  input  1  memory completes the access this cycle; mem_rdata is valid in the same cycle.
- mem_rdata  input  Width  read word.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata.
  - Valid funct3: loads 000/001/010/100/101; stores 000/001/010. Any other encoding goes to RESP with err=1.
  - Otherwise go to ACC0.
- Size n is 1, 2 or 4 bytes from funct3[1:0]. Offset o = addr[1:0]. The access is split when o+n > 4.
- ACC0:
  - Drives mem_addr = {addr[31:2], 2'b00}.
  - mem_be = low 4 bits of (((1<<n)-1) << o).
  - mem_wdata = wdata << 8*o.
  - Holds all outputs until mem_ready.
  - On mem_ready, capture mem_rdata as rd0, then go to ACC1 if split, else RESP.
- ACC1:
  - mem_addr = ACC0 address + 4, mod 2^32 (0xFFFFFFFC wraps to 0).
  - mem_be = ((1<<n)-1) >> (4-o).
  - mem_wdata = wdata >> 8*(4-o).
  - On mem_ready, capture rd1 and go to RESP.
- Load data path:
  - d = ({rd1, rd0} >> 8*o), keeping the low n bytes.
  - Sign-extend for funct3 000/001; zero-extend for 100/101.
  - Little-endian throughout.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response backpressure.
- MemRead = ACC state and !write. MemWrite = ACC state and write. They are never both high.
- Outside ACC states: mem_be=0, and mem_addr and mem_wdata are 0.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Reset takes effect immediately, including mid-access. Strobes drop asynchronously, no response is issued, and the in-flight request is discarded.
- Latency (request accepted in cycle 0, mem_ready tied high):
  - Aligned: ACC0 in cycle 1, resp_valid in cycle 2.
  - Split: resp_valid in cycle 3.
  - Invalid funct3: resp_valid in cycle 1.
- Each cycle of mem_ready low adds one cycle. Memory outputs stay stable while waiting.
- req_ready=0 in ACC0, ACC1 and RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- resp_rdata and resp_err are registered and valid only while resp_valid=1.

## Test plan
- Memory word 0x100=0x44332211, 0x104=0x88776655, mem_ready=1.
  - LW 0x100 -> one read, mem_be=1111, resp_rdata=0x44332211 in cycle 2.
- Sign and zero extension:
  - LB 0x103 -> 0x00000044.
  - LB 0x107 -> 0xFFFFFF88.
  - LBU 0x107 -> 0x00000088.
  - LH 0x106 -> 0xFFFF8877.
- LW 0x102 -> reads at 0x100 then 0x104; resp_rdata=0x66554433 in cycle 3.
  - LHU 0x103 -> 0x00005544.
- SH 0x103, wdata 0x0000BEEF -> two writes:
  - First: 0x100, be=1000, data 0xEF000000.
  - Second: 0x104, be=0001, data 0x000000BE.
  - resp_rdata=0.
- mem_ready low for 3 cycles on LW 0x100:
  - MemRead, addr and be held stable; resp in cycle 5.
- funct3=011 load -> resp_valid=1 with resp_err=1 in cycle 1, and no MemRead/MemWrite ever asserted.
- rst pulsed during ACC1 of a split load -> MemRead=0 immediately, no resp_valid, req_ready=1 once rst drops.
